// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory.
// Receives a length-prefixed, XOR-checksummed byte stream over a valid/ready
// link, assembles little-endian 32-bit words, writes them to the instruction
// memory and releases the core reset only after the checksum matches.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_ready is a pure decode of the state register (high in HDR0, HDR1, DATA
// and CSUM) and never depends on rx_valid.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_resetn,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    n_lo_q;
  logic [15:0]   n_q;
  logic [15:0]   idx_q;
  logic [1:0]    lane_q;
  logic [23:0]   asm_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] idle_q;

  logic          accept;
  logic          arm;
  logic          counting;
  logic          timeout_hit;
  logic [15:0]   n_hdr;
  logic          len_bad;
  logic          last_word;

  // Status decodes of the state register
  assign rx_ready   = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign busy       = rx_ready;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign cpu_resetn = (state_q == ST_DONE);
  assign error_code = code_q;

  assign accept      = rx_valid && rx_ready;
  // A start pulse is only honoured while no load is in progress
  assign arm         = start && !busy;
  // HDR0 is excluded so a host may wait indefinitely before sending a header
  assign counting    = (state_q == ST_HDR1) || (state_q == ST_DATA) ||
                       (state_q == ST_CSUM);
  assign timeout_hit = counting && (idle_q == IDLE_LIMIT);
  assign n_hdr       = {rx_data, n_lo_q};
  assign len_bad     = (n_hdr == 16'd0) || ({16'd0, n_hdr} > 32'(DEPTH_WORDS));
  assign last_word   = (idx_q == (n_q - 16'd1));

  // Next-state and error-code selection; an accepted byte beats a timeout
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (arm) begin
          state_d = ST_HDR0;
          code_d  = 2'b00;
        end
      end
      ST_HDR0: begin
        if (accept) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (accept) begin
          if (len_bad) begin
            state_d = ST_ERROR;
            code_d  = 2'b01;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
          code_d  = 2'b11;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if ((lane_q == 2'd3) && last_word) state_d = ST_CSUM;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
          code_d  = 2'b11;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            code_d  = 2'b10;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
          code_d  = 2'b11;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = 2'b00;
      end
    endcase
  end

  // State and error-code registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Idle counter: cleared on arm, in HDR0 and on every accepted byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (arm || accept || (state_q == ST_HDR0)) begin
      idle_q <= '0;
    end else if (counting) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  // Header capture, word assembly, checksum and memory write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_lo_q     <= 8'd0;
      n_q        <= 16'd0;
      idx_q      <= 16'd0;
      lane_q     <= 2'd0;
      asm_q      <= 24'd0;
      csum_q     <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (arm) begin
        idx_q  <= 16'd0;
        lane_q <= 2'd0;
        csum_q <= 8'd0;
      end
      if (accept && (state_q == ST_HDR0)) n_lo_q <= rx_data;
      if (accept && (state_q == ST_HDR1)) n_q <= n_hdr;
      if (accept && (state_q == ST_DATA)) begin
        csum_q <= csum_q ^ rx_data;
        lane_q <= lane_q + 2'd1;
        case (lane_q)
          2'd0: asm_q[7:0]   <= rx_data;
          2'd1: asm_q[15:8]  <= rx_data;
          2'd2: asm_q[23:16] <= rx_data;
          default: begin
            imem_we    <= 1'b1;
            imem_wdata <= {rx_data, asm_q};
            imem_addr  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
            idx_q      <= idx_q + 16'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for the instruction memory loader.
// Expected writes are queued when a stream is driven and checked by a
// monitor on the falling edge whenever imem_we is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_resetn;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  error_code;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  logic [7:0] good_s [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};

  imem_loader #(
    .DEPTH_WORDS   (256),
    .BASE_ADDR     (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_resetn(cpu_resetn),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .error_code(error_code)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the head of exp_q
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst && imem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write got addr=%h data=%h want none", imem_addr, imem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp) begin
          n_bad++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   imem_addr, imem_wdata, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // Driver: present one byte, wait for the handshake edge, return at negedge
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard;
    if (rnd) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_ready got rx_ready=0 want 1 within 50 cycles");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends the good stream with a chosen checksum byte; optional start pulse
  task automatic send_stream(input logic [7:0] csum, input bit rnd, input int start_after);
    for (int i = 0; i < 10; i++) begin
      send_byte(good_s[i], rnd);
      if (i == start_after) pulse_start();
    end
    send_byte(csum, rnd);
  endtask

  task automatic push_good_writes();
    exp_q.push_back({32'h0000_0000, 32'h0050_0013});
    exp_q.push_back({32'h0000_0004, 32'h0010_0093});
  endtask

  task automatic wait_end(input int budget);
    int i = 0;
    while (!(done || error) && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (i >= budget) begin
      n_bad++;
      $display("FAIL wait_end got no done/error want one within %0d cycles", budget);
    end
  endtask

  task automatic check_queue_empty(input string tag);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_writes got %0d missing writes want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_ready, imem_we, cpu_resetn, busy, done, error, error_code} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_flags got rdy=%b we=%b rn=%b busy=%b done=%b err=%b code=%b want all 0",
               rx_ready, imem_we, cpu_resetn, busy, done, error, error_code);
    end
    n_cmp++;
    if ({imem_addr, imem_wdata} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_bus got addr=%h data=%h want 0/0", imem_addr, imem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_load();
    push_good_writes();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || rx_ready !== 1'b1 || cpu_resetn !== 1'b0) begin
      n_bad++;
      $display("FAIL good_armed got busy=%b rdy=%b rn=%b want 1/1/0", busy, rx_ready, cpu_resetn);
    end
    send_stream(8'hC0, 1'b0, -1);
    wait_end(20);
    n_cmp++;
    if ({done, error, cpu_resetn, busy, error_code} !== 6'b101000) begin
      n_bad++;
      $display("FAIL good_result got done=%b err=%b rn=%b busy=%b code=%b want 1/0/1/0/00",
               done, error, cpu_resetn, busy, error_code);
    end
    n_cmp++;
    if (imem_addr !== 32'h4 || imem_wdata !== 32'h0010_0093) begin
      n_bad++;
      $display("FAIL good_hold got addr=%h data=%h want 4/00100093", imem_addr, imem_wdata);
    end
    check_queue_empty("good");
  endtask

  task automatic test_bad_csum();
    push_good_writes();
    pulse_start();
    n_cmp++;
    if (cpu_resetn !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rearm_from_done got rn=%b done=%b busy=%b want 0/0/1", cpu_resetn, done, busy);
    end
    send_stream(8'hC1, 1'b0, -1);
    wait_end(20);
    n_cmp++;
    if ({done, error, cpu_resetn, error_code} !== 5'b01010) begin
      n_bad++;
      $display("FAIL csum_result got done=%b err=%b rn=%b code=%b want 0/1/0/10",
               done, error, cpu_resetn, error_code);
    end
    check_queue_empty("csum");
  endtask

  task automatic test_bad_len(input logic [7:0] lo, input logic [7:0] hi, input string tag);
    pulse_start();
    n_cmp++;
    if (error !== 1'b0 || error_code !== 2'b00) begin
      n_bad++;
      $display("FAIL %s_clear got err=%b code=%b want 0/00", tag, error, error_code);
    end
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    n_cmp++;
    if ({error, error_code, rx_ready, busy, cpu_resetn} !== 6'b101000) begin
      n_bad++;
      $display("FAIL %s got err=%b code=%b rdy=%b busy=%b rn=%b want 1/01/0/0/0",
               tag, error, error_code, rx_ready, busy, cpu_resetn);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    pulse_start();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hdr0_no_timeout got err=%b busy=%b want 0/1", error, busy);
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    // Byte arrives on the very edge the idle count reaches the limit
    repeat (15) @(negedge clk);
    send_byte(8'h00, 1'b0);
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL byte_beats_timeout got err=%b busy=%b want 0/1", error, busy);
    end
    repeat (15) @(negedge clk);
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early got err=%b want 0 after 15 idle cycles", error);
    end
    @(negedge clk);
    n_cmp++;
    if ({error, error_code, rx_ready, cpu_resetn} !== 5'b11100) begin
      n_bad++;
      $display("FAIL timeout got err=%b code=%b rdy=%b rn=%b want 1/11/0/0",
               error, error_code, rx_ready, cpu_resetn);
    end
  endtask

  task automatic test_random_valid();
    push_good_writes();
    pulse_start();
    send_stream(8'hC0, 1'b1, 6);
    wait_end(40);
    n_cmp++;
    if ({done, error, cpu_resetn, error_code} !== 5'b10100) begin
      n_bad++;
      $display("FAIL random_result got done=%b err=%b rn=%b code=%b want 1/0/1/00",
               done, error, cpu_resetn, error_code);
    end
    check_queue_empty("random");
  endtask

  task automatic test_reset_midload();
    exp_q.push_back({32'h0000_0000, 32'h0050_0013});
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(good_s[i], 1'b0);
    check_queue_empty("midload_first");
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rx_ready, imem_we, cpu_resetn, busy, done, error, error_code} !== 8'b0 ||
        imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset got rdy=%b we=%b rn=%b busy=%b addr=%h data=%h want 0s",
               rx_ready, imem_we, cpu_resetn, busy, imem_addr, imem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_good_load();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_load();
    test_bad_csum();
    test_bad_len(8'h00, 8'h00, "len_zero");
    test_bad_len(8'h01, 8'h01, "len_257");
    test_timeout();
    test_random_valid();
    test_reset_midload();
    repeat (4) @(negedge clk);
    check_queue_empty("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It takes a serial byte stream from a host link with a valid/ready handshake and validates a length header. It assembles little-endian 32-bit instruction words and writes them through the instruction memory write port. It holds the processor core in reset until a checksum-verified image is in place, and only then releases it.

Parameters:
DEPTH_WORDS, 256, instruction memory depth in 32-bit words; maximum legal image length.
BASE_ADDR, 32'h00000000, byte address of the first written word.
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between accepted bytes once a header has started.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; arms a new load
rx_data  input  8  byte from host link
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts rx_data; a byte transfers when rx_valid && rx_ready at a clk edge
imem_we  output  1  one-cycle instruction memory write strobe
imem_addr  output  32  byte address of the word being written (word aligned)
imem_wdata  output  32  word being written
cpu_resetn  output  1  active-low hold for the processor core; 0 = core held in reset
busy  output  1  load in progress
done  output  1  image loaded and verified; sticky until next start/reset
error  output  1  load failed; sticky until next start/reset
error_code  output  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout

Behaviour:
- Reset (asynchronous, active-high): state IDLE. rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_resetn=0, busy=0, done=0, error=0, error_code=00.
- Stream format: byte 0 = N[7:0], byte 1 = N[15:8], then 4*N payload bytes, then 1 checksum byte.
  - Each word is sent least-significant byte first.
  - Checksum = XOR of all payload bytes; header bytes are excluded.
- States: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR with start=1 -> HDR0 on the next edge.
  - On that edge: busy=1, done=0, error=0, error_code=00, cpu_resetn=0, word index=0, byte lane=0, checksum accumulator=0.
- start while busy=1 is ignored.
- rx_ready=1 exactly in HDR0, HDR1, DATA, CSUM; 0 in all other states.
- HDR0: accept byte -> N low byte, go to HDR1. No timeout applies in HDR0.
- HDR1: accept byte -> N high byte.
  - If N==0 or N>DEPTH_WORDS -> ERROR with code 01.
  - Otherwise -> DATA.
- DATA: each accepted byte is placed in lane 0..3 of the assembly register and XORed into the checksum.
  - On the 4th byte: imem_wdata = assembled word, imem_addr = BASE_ADDR + 4*index, imem_we=1 for exactly the following cycle.
  - Write latency: 1 cycle after the 4th byte handshake.
  - The index then increments; byte acceptance continues in the same cycle as the strobe, with no bubble.
  - After word N-1 -> CSUM.
- CSUM: accept byte.
  - Equal to the accumulator -> DONE.
  - Otherwise -> ERROR with code 10.
- DONE: busy=0, done=1, cpu_resetn=1 on the same edge the state is entered.
- ERROR: busy=0, error=1, cpu_resetn stays 0.
- Timeout: idle counter clears on every accepted byte and on entry to HDR0. It counts while in HDR1, DATA or CSUM; reaching TIMEOUT_CYCLES -> ERROR with code 11.
  - If a byte is accepted in the same cycle the counter reaches the limit, the byte wins.
- imem_addr and imem_wdata hold their last values between strobes. Writes already issued before an error are not undone.
- Reset asserted mid-load aborts immediately to reset values; no further imem_we; cpu_resetn=0.
- Start asserted in DONE re-holds the core: cpu_resetn falls on the edge that enters HDR0.

Test Plan:
- Reset, start, send 02 00 13 00 50 00 93 00 10 00 C0 -> imem_we twice: addr 0x0 data 0x00500013, then addr 0x4 data 0x00100093; done=1, cpu_resetn=1, error_code=00.
- Same stream with checksum byte C1 -> both writes occur; error=1, error_code=10, cpu_resetn=0, done=0.
- Header 00 00, and separately header 01 01 (N=257 > 256) -> ERROR with code 01, no imem_we, rx_ready=0 after the header.
- TIMEOUT_CYCLES=16; send header 01 00 and 2 payload bytes, then hold rx_valid=0 -> error_code=11 exactly 16 cycles after the last accepted byte.
- rx_valid toggling randomly during the first scenario's stream, plus a start pulse mid-load -> identical writes and result; the mid-load start has no effect.
- Assert reset after the 5th payload byte of a 2-word load -> all outputs return to reset values asynchronously; a fresh start/load then succeeds from address 0x0.
